// File: rtl/gpio_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_uart_bridge                                                |
// | Purpose  : captures processor GPIO bytes on strobe falling edges, buffers  |
// |            them in a FIFO and streams them out as UART 8N1 frames.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module gpio_uart_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 152100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  GPIO,
  input  logic        GPIOEn,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic        frame_done,
  output logic [17:0] tx_count
);

  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_LVL_W = C_PTR_W + 1;
  localparam int C_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [C_LVL_W-1:0] C_FIFO_FULL  = C_LVL_W'(FIFO_DEPTH);
  localparam logic [C_CNT_W-1:0] C_BIT_LAST   = C_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [17:0]        C_FRAME_LAST = 18'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_gpioen_q;
  logic                 r_rst_q;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_LVL_W-1:0]   r_level;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_next;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_next;
  logic [C_CNT_W-1:0]   r_clk_cnt;
  logic [C_CNT_W-1:0]   w_clk_cnt_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_overflow;
  logic                 r_frame_done;
  logic [17:0]          r_tx_count;
  logic                 w_capture;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_byte_done;

  // r_rst_q masks the first post-reset cycle, where r_gpioen_q=1 would fake an edge.
  assign w_capture = r_gpioen_q & ~GPIOEn & ~r_rst_q;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == C_FIFO_FULL);
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_bit_end = (r_clk_cnt == C_BIT_LAST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= GPIO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpioen_q <= 1'b1;
      r_rst_q    <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_gpioen_q <= GPIOEn;
      r_rst_q    <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_capture && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tx         <= 1'b1;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_clk_cnt    <= '0;
      r_tx_count   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tx         <= w_tx_next;
      r_shift      <= w_shift_next;
      r_bit_idx    <= w_bit_idx_next;
      r_clk_cnt    <= w_clk_cnt_next;
      r_frame_done <= 1'b0;
      if (w_byte_done) begin
        if (r_tx_count == C_FRAME_LAST) begin
          r_tx_count   <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_tx_count <= r_tx_count + 18'd1;
        end
      end
    end
  end

  // Next-state values for the serial line are computed here and registered above,
  // so tx leaves the block straight from a flop.
  always_comb begin
    w_state_next   = r_state;
    w_tx_next      = r_tx;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_clk_cnt_next = r_clk_cnt + 1'b1;
    w_pop          = 1'b0;
    w_byte_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_next      = 1'b1;
        w_clk_cnt_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_tx_next    = 1'b0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_tx_next      = r_shift[0];
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_byte_done    = 1'b1;
          w_state_next   = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign tx         = r_tx;
  assign busy       = ~w_empty | (r_state != S_IDLE);
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;
  assign tx_count   = r_tx_count;

endmodule
`default_nettype wire

// File: tb/tb_gpio_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gpio_uart_bridge                                             |
// | Purpose  : directed self-checking bench for gpio_uart_bridge.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_gpio_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  GPIO = 8'h00;
  logic        GPIOEn = 1'b1;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic        frame_done;
  logic [17:0] tx_count;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  mon_bytes[$];
  int          mon_starts[$];
  int          fd_n = 0;
  int          fd_cyc = 0;
  logic [17:0] fd_prev = '0;
  logic [17:0] fd_now = '0;
  logic [17:0] last_cnt = '0;

  gpio_uart_bridge #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .FRAME_PIXELS(FRAME)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .GPIO      (GPIO),
    .GPIOEn    (GPIOEn),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .frame_done(frame_done),
    .tx_count  (tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent UART receiver: samples each bit in its middle cycle.
  initial begin : uart_monitor
    logic [7:0] b;
    forever begin
      @(posedge clk); #2;
      if (mon_en && tx === 1'b0) begin
        mon_starts.push_back(cyc);
        repeat (CPB + CPB / 2) @(posedge clk);
        #2;
        for (int k = 0; k < 8; k++) begin
          b[k] = tx;
          repeat (CPB) @(posedge clk);
          #2;
        end
        mon_bytes.push_back(b);
      end
    end
  end

  initial begin : fd_monitor
    forever begin
      @(posedge clk); #2;
      if (frame_done === 1'b1) begin
        fd_n++;
        fd_cyc  = cyc;
        fd_prev = last_cnt;
        fd_now  = tx_count;
      end
      last_cnt = tx_count;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] got_byte(input int idx);
    if (idx < mon_bytes.size()) return mon_bytes[idx];
    return 8'hxx;
  endfunction

  function automatic int got_start(input int idx);
    if (idx < mon_starts.size()) return mon_starts[idx];
    return -1000;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input logic en_level);
    rst = 1'b1; GPIOEn = en_level; GPIO = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic strobe(input logic [7:0] b);
    GPIO = b; GPIOEn = 1'b0; tick();
    GPIOEn = 1'b1; tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin tick(); n++; end
    checks++; if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", tag, busy, n); else passes++;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; GPIOEn = 1'b1; GPIO = 8'h00;
    repeat (2) tick();
    checks++; if (tx !== 1'b1)          $display("FAIL reset_tx: got %b want 1", tx); else passes++;
    checks++; if (busy !== 1'b0)        $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (overflow !== 1'b0)    $display("FAIL reset_overflow: got %b want 0", overflow); else passes++;
    checks++; if (frame_done !== 1'b0)  $display("FAIL reset_frame_done: got %b want 0", frame_done); else passes++;
    checks++; if (tx_count !== 18'd0)   $display("FAIL reset_tx_count: got %0d want 0", tx_count); else passes++;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    logic [9:0] frame;
    int base;
    apply_reset(1'b1);
    base  = mon_bytes.size();
    frame = {1'b1, 8'hA5, 1'b0};
    GPIO = 8'hA5; GPIOEn = 1'b0; tick();
    GPIOEn = 1'b1;
    checks++; if (tx !== 1'b1)   $display("FAIL single_latency_n1: tx=%b want 1", tx); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy_n1: busy=%b want 1", busy); else passes++;
    tick();
    for (int i = 0; i < 40; i++) begin
      checks++; if (tx !== frame[i / 4]) $display("FAIL single_wave cycle N+%0d: tx=%b want %b", i + 2, tx, frame[i / 4]); else passes++;
      tick();
    end
    checks++; if (busy !== 1'b0)          $display("FAIL single_busy_end: busy=%b want 0", busy); else passes++;
    checks++; if (tx_count !== 18'd1)     $display("FAIL single_tx_count: got %0d want 1", tx_count); else passes++;
    checks++; if (got_byte(base) !== 8'hA5) $display("FAIL single_byte: got %h want a5", got_byte(base)); else passes++;
  endtask

  task automatic test_burst();
    int base, sbase, gap;
    apply_reset(1'b1);
    base = mon_bytes.size(); sbase = mon_starts.size();
    for (int i = 0; i < 4; i++) strobe(8'(i + 1));
    wait_idle("burst");
    checks++; if (mon_bytes.size() - base !== 4) $display("FAIL burst_count: got %0d want 4", mon_bytes.size() - base); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_byte(base + i) !== 8'(i + 1)) $display("FAIL burst_byte%0d: got %h want %h", i, got_byte(base + i), 8'(i + 1)); else passes++;
    end
    for (int i = 0; i < 3; i++) begin
      gap = got_start(sbase + i + 1) - got_start(sbase + i);
      checks++; if (gap < 40 || gap > 41) $display("FAIL burst_spacing%0d: got %0d cycles want 40..41", i, gap); else passes++;
    end
    checks++; if (overflow !== 1'b0)      $display("FAIL burst_overflow: got %b want 0", overflow); else passes++;
    checks++; if (tx_count !== 18'd1)     $display("FAIL burst_tx_count: got %0d want 1", tx_count); else passes++;
  endtask

  task automatic test_overflow();
    int base;
    apply_reset(1'b1);
    base = mon_bytes.size();
    for (int i = 0; i < 5; i++) strobe(8'h10 + 8'(i));
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_full_no_drop: overflow=%b want 0", overflow); else passes++;
    strobe(8'h15);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: overflow=%b want 1", overflow); else passes++;
    wait_idle("ovf");
    checks++; if (mon_bytes.size() - base !== 5) $display("FAIL ovf_count: got %0d want 5", mon_bytes.size() - base); else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (got_byte(base + i) !== 8'h10 + 8'(i)) $display("FAIL ovf_byte%0d: got %h want %h", i, got_byte(base + i), 8'h10 + 8'(i)); else passes++;
    end
    checks++; if (overflow !== 1'b1)  $display("FAIL ovf_sticky: overflow=%b want 1", overflow); else passes++;
    checks++; if (tx_count !== 18'd2) $display("FAIL ovf_tx_count: got %0d want 2", tx_count); else passes++;
  endtask

  task automatic test_frame();
    int sbase, fbase;
    apply_reset(1'b1);
    sbase = mon_starts.size(); fbase = fd_n;
    strobe(8'hC1); strobe(8'hC2); strobe(8'hC3);
    wait_idle("frame");
    checks++; if (fd_n - fbase !== 1)   $display("FAIL frame_pulses: got %0d want 1", fd_n - fbase); else passes++;
    checks++; if (fd_prev !== 18'd2)    $display("FAIL frame_count_before: got %0d want 2", fd_prev); else passes++;
    checks++; if (fd_now !== 18'd0)     $display("FAIL frame_count_at_pulse: got %0d want 0", fd_now); else passes++;
    checks++; if (fd_cyc !== got_start(sbase + 2) + 40) $display("FAIL frame_pulse_cycle: got %0d want %0d", fd_cyc, got_start(sbase + 2) + 40); else passes++;
    strobe(8'hC4);
    wait_idle("frame4");
    checks++; if (tx_count !== 18'd1)   $display("FAIL frame_after_wrap: got %0d want 1", tx_count); else passes++;
    checks++; if (fd_n - fbase !== 1)   $display("FAIL frame_extra_pulse: got %0d want 1", fd_n - fbase); else passes++;
  endtask

  task automatic test_edge_filter();
    int base;
    apply_reset(1'b1);
    base = mon_bytes.size();
    GPIO = 8'h3C; GPIOEn = 1'b0;
    repeat (20) tick();
    GPIO = 8'h77; GPIOEn = 1'b1;
    repeat (5) tick();
    wait_idle("edge");
    checks++; if (mon_bytes.size() - base !== 1) $display("FAIL edge_count: got %0d want 1", mon_bytes.size() - base); else passes++;
    checks++; if (got_byte(base) !== 8'h3C)      $display("FAIL edge_byte: got %h want 3c", got_byte(base)); else passes++;
    checks++; if (tx_count !== 18'd1)            $display("FAIL edge_tx_count: got %0d want 1", tx_count); else passes++;
  endtask

  task automatic test_post_reset();
    int base;
    apply_reset(1'b0);
    base = mon_bytes.size();
    repeat (10) tick();
    checks++; if (busy !== 1'b0) $display("FAIL postrst_busy: got %b want 0", busy); else passes++;
    checks++; if (tx !== 1'b1)   $display("FAIL postrst_tx: got %b want 1", tx); else passes++;
    checks++; if (mon_bytes.size() - base !== 0) $display("FAIL postrst_bytes: got %0d want 0", mon_bytes.size() - base); else passes++;
    GPIOEn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int lows = 0;
    int busies = 0;
    apply_reset(1'b1);
    strobe(8'hF0); strobe(8'h0F); strobe(8'h55);
    repeat (4) tick();
    mon_en = 1'b0;
    rst = 1'b1; tick();
    checks++; if (tx !== 1'b1)        $display("FAIL rstmid_tx: got %b want 1", tx); else passes++;
    checks++; if (busy !== 1'b0)      $display("FAIL rstmid_busy: got %b want 0", busy); else passes++;
    checks++; if (tx_count !== 18'd0) $display("FAIL rstmid_tx_count: got %0d want 0", tx_count); else passes++;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
      tick();
    end
    checks++; if (lows !== 0)   $display("FAIL rstmid_no_tx: %0d low cycles want 0", lows); else passes++;
    checks++; if (busies !== 0) $display("FAIL rstmid_no_busy: %0d busy cycles want 0", busies); else passes++;
    mon_en = 1'b1;
  endtask

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_frame();
    test_edge_filter();
    test_post_reset();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
